// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array datapath: default lane width,
// Q8.8 fixed-point format constant and the west-edge skew feeder states.
package tpu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int Q8_8_FRAC_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

endpackage

// File: rtl/systolic_input_skew_lane.sv
// One row of the skew feeder: a DEPTH-stage shift register carrying
// {data, valid, switch}. The last stage drives the PE column 0 input directly.
module skew_lane
  import tpu_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  input  logic                         in_switch,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic                         out_switch
);

  logic signed [DATA_WIDTH-1:0] data_p [DEPTH];
  logic                         vld_p  [DEPTH];
  logic                         sw_p   [DEPTH];

  // Shift the lane one stage per cycle; reset wipes any partial wavefront.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_p[s] <= '0;
        vld_p[s]  <= 1'b0;
        sw_p[s]   <= 1'b0;
      end
    end else begin
      data_p[0] <= in_data;
      vld_p[0]  <= in_valid;
      sw_p[0]   <= in_switch;
      for (int s = 1; s < DEPTH; s++) begin
        data_p[s] <= data_p[s-1];
        vld_p[s]  <= vld_p[s-1];
        sw_p[s]   <= sw_p[s-1];
      end
    end
  end

  assign out_data   = data_p[DEPTH-1];
  assign out_valid  = vld_p[DEPTH-1];
  assign out_switch = sw_p[DEPTH-1];

endmodule

// File: rtl/systolic_input_skew.sv
// West-edge feeder: accepts one row vector per cycle and delays lane i by i
// extra cycles, producing the diagonal wavefront for PE column 0. Between
// tiles the feeder stalls ROWS-1 cycles so skewed lanes never overlap.
module systolic_input_skew
  import tpu_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_switch,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] out_input,
  output logic [ROWS-1:0]            out_valid,
  output logic [ROWS-1:0]            out_switch,
  output logic                       busy,
  output logic [15:0]                vec_count
);

  skew_state_e state;
  logic [4:0]  drain_cnt;
  logic        ready_q;
  logic        busy_q;
  logic        accept;
  logic        switch_in;

  assign accept    = in_valid && ready_q;
  // Only the first vector of a tile may carry the weight-switch marker.
  assign switch_in = accept && (state == IDLE) && in_switch;
  assign in_ready  = ready_q;
  assign busy      = busy_q;

  // Tile sequencing: ready and busy are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      vec_count <= '0;
    end else begin
      unique case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (!in_last) begin
              state     <= STREAM;
              busy_q    <= 1'b1;
              vec_count <= vec_count + 16'd1;
            end else if (ROWS == 1) begin
              // A single lane has nothing to drain.
              state     <= IDLE;
              busy_q    <= 1'b0;
              vec_count <= '0;
            end else begin
              state     <= DRAIN;
              busy_q    <= 1'b1;
              ready_q   <= 1'b0;
              drain_cnt <= '0;
              vec_count <= vec_count + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 5'(ROWS - 2)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            vec_count <= '0;
          end else begin
            drain_cnt <= drain_cnt + 5'd1;
          end
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] lane_in;
    logic signed [DATA_WIDTH-1:0] lane_out;

    // Non-accepting cycles inject an all-zero bubble.
    assign lane_in = accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_lane #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .in_data    (lane_in),
      .in_valid   (accept),
      .in_switch  (switch_in),
      .out_data   (lane_out),
      .out_valid  (out_valid[i]),
      .out_switch (out_switch[i])
    );

    assign out_input[i*DATA_WIDTH +: DATA_WIDTH] = lane_out;
  end

endmodule

// File: tb/tb_systolic_input_skew.sv
// Directed bench for the skew feeder: a ROWS=2 instance covering tiles,
// bubbles, switch handling and mid-tile reset, and a ROWS=1 instance.
module tb_systolic_input_skew;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_switch = 1'b0, in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, busy;
  logic [31:0] out_input;
  logic [1:0]  out_valid, out_switch;
  logic [15:0] vec_count;

  logic        in_valid1 = 1'b0, in_switch1 = 1'b0, in_last1 = 1'b0;
  logic [15:0] in_data1 = '0;
  logic        in_ready1, busy1;
  logic [15:0] out_input1;
  logic [0:0]  out_valid1, out_switch1;
  logic [15:0] vec_count1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_input_skew #(.ROWS(2), .DATA_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_switch(in_switch), .in_last(in_last),
    .out_input(out_input), .out_valid(out_valid), .out_switch(out_switch),
    .busy(busy), .vec_count(vec_count)
  );

  systolic_input_skew #(.ROWS(1), .DATA_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_switch(in_switch1), .in_last(in_last1),
    .out_input(out_input1), .out_valid(out_valid1), .out_switch(out_switch1),
    .busy(busy1), .vec_count(vec_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full ROWS=2 output snapshot.
  task automatic chk2(input string tag, input logic [31:0] d, input logic [1:0] v,
                      input logic [1:0] s, input logic rdy, input logic b,
                      input logic [15:0] vc);
    chk({tag, ".out_input"}, out_input, d);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_switch"}, 32'(out_switch), 32'(s));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".vec_count"}, 32'(vec_count), 32'(vc));
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic l);
    in_valid  = v;
    in_data   = d;
    in_switch = s;
    in_last   = l;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk2("reset", 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0);
    rst = 1'b0;
    tick();
    chk2("post_reset", 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0);

    // Tile 1: three vectors, switch on the first
    drive(1'b1, 32'h0400_0100, 1'b1, 1'b0);
    tick();
    chk2("t1v1", 32'h0000_0100, 2'b01, 2'b01, 1'b1, 1'b1, 16'd1);
    drive(1'b1, 32'h0500_0200, 1'b0, 1'b0);
    tick();
    chk2("t1v2", 32'h0400_0200, 2'b11, 2'b10, 1'b1, 1'b1, 16'd2);
    drive(1'b1, 32'h0600_0300, 1'b0, 1'b1);
    tick();
    chk2("t1v3", 32'h0500_0300, 2'b11, 2'b00, 1'b0, 1'b1, 16'd3);

    // Drain: next tile's first vector is offered but not taken
    drive(1'b1, 32'h0800_0700, 1'b1, 1'b0);
    tick();
    chk2("drain", 32'h0600_0000, 2'b10, 2'b00, 1'b1, 1'b0, 16'd0);

    // Tile 2 accepted back-to-back, switch captured in IDLE
    tick();
    chk2("t2v1", 32'h0000_0700, 2'b01, 2'b01, 1'b1, 1'b1, 16'd1);

    // Mid-tile bubble
    drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    chk2("bubble", 32'h0800_0000, 2'b10, 2'b10, 1'b1, 1'b1, 16'd1);

    // Switch on a later vector is ignored
    drive(1'b1, 32'h0A00_0900, 1'b1, 1'b0);
    tick();
    chk2("t2v2", 32'h0000_0900, 2'b01, 2'b00, 1'b1, 1'b1, 16'd2);
    drive(1'b1, 32'h0C00_0B00, 1'b1, 1'b1);
    tick();
    chk2("t2v3", 32'h0A00_0B00, 2'b11, 2'b00, 1'b0, 1'b1, 16'd3);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk2("t2drain", 32'h0C00_0000, 2'b10, 2'b00, 1'b1, 1'b0, 16'd0);
    tick();
    chk2("idle", 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0);

    // Reset one cycle after the first accept of a tile
    drive(1'b1, 32'h0E00_0D00, 1'b1, 1'b0);
    tick();
    chk2("pre_rst", 32'h0000_0D00, 2'b01, 2'b01, 1'b1, 1'b1, 16'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk2("rst_async", 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    chk2("post_rst1", 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0);
    tick();
    chk2("post_rst2", 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0);

    // ROWS=1: single-vector tile with switch, ready never drops
    in_valid1 = 1'b1; in_data1 = 16'h1234; in_switch1 = 1'b1; in_last1 = 1'b1;
    chk("r1.ready_before", 32'(in_ready1), 32'd1);
    tick();
    chk("r1.out_input", 32'(out_input1), 32'h1234);
    chk("r1.out_valid", 32'(out_valid1), 32'd1);
    chk("r1.out_switch", 32'(out_switch1), 32'd1);
    chk("r1.in_ready", 32'(in_ready1), 32'd1);
    chk("r1.busy", 32'(busy1), 32'd0);
    chk("r1.vec_count", 32'(vec_count1), 32'd0);
    // Two-vector tile on one lane
    in_data1 = 16'h0011; in_switch1 = 1'b0; in_last1 = 1'b0;
    tick();
    chk("r1.v1_out", 32'(out_input1), 32'h0011);
    chk("r1.v1_switch", 32'(out_switch1), 32'd0);
    chk("r1.v1_busy", 32'(busy1), 32'd1);
    chk("r1.v1_count", 32'(vec_count1), 32'd1);
    in_data1 = 16'h0022; in_last1 = 1'b1;
    tick();
    chk("r1.v2_out", 32'(out_input1), 32'h0022);
    chk("r1.v2_ready", 32'(in_ready1), 32'd1);
    chk("r1.v2_busy", 32'(busy1), 32'd0);
    in_valid1 = 1'b0; in_data1 = 16'h0; in_last1 = 1'b0;
    tick();
    chk("r1.after_valid", 32'(out_valid1), 32'd0);
    chk("r1.after_data", 32'(out_input1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_input_skew.md
# systolic_input_skew

West-edge feeder for the systolic array. Accepts one row vector per cycle over a valid/ready handshake and delays lane `i` by `i` extra cycles. The result is the diagonal wavefront the PE grid needs. It drives each row's input, valid and switch wires into column 0. Skewed lanes drain between tiles so the output shape stays correct.

## Interface
Parameters:
- `ROWS`, 2, number of array rows (lanes); legal range 1..16
- `DATA_WIDTH`, 16, lane width; signed Q8.8 fixed-point, carried through unmodified

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  upstream vector valid
- `in_ready`  out  1  block can accept a vector this cycle
- `in_data`  in  ROWS*DATA_WIDTH  lane `i` at bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `in_switch`  in  1  tile uses newly loaded weights; sampled only on the first vector of a tile
- `in_last`  in  1  marks the final vector of a tile
- `out_input`  out  ROWS*DATA_WIDTH  per-row input to PE column 0
- `out_valid`  out  ROWS  per-row valid
- `out_switch`  out  ROWS  per-row weight-switch pulse
- `busy`  out  1  state is not IDLE
- `vec_count`  out  16  vectors accepted in the current tile; wraps modulo 2^16

## Operation
- A vector is accepted when `in_valid && in_ready`.
- States:
  - IDLE: waiting for a tile.
  - STREAM: mid-tile.
  - DRAIN: skew pipeline emptying.
- State transitions:
  - IDLE→STREAM on an accept without `in_last`.
  - IDLE→DRAIN on an accept with `in_last` (single-vector tile).
  - STREAM→DRAIN on an accept with `in_last`.
  - DRAIN→IDLE once the drain counter reaches ROWS-1 cycles.
  - With ROWS=1, DRAIN lasts 0 cycles: an accept with `in_last` returns directly to IDLE.
- `in_ready` is 1 in IDLE and STREAM, and 0 in DRAIN.
- Switch handling:
  - `in_switch` is captured only on an accept in IDLE.
  - It rides with that vector; `out_switch[i]` pulses in the same cycle the vector's lane `i` appears.
  - `in_switch` on any later vector of the tile is ignored.
- Lane `i` pipeline is `i+1` registers deep. Each stage holds {data, valid, switch}.
- Non-accepting cycles inject a bubble: valid=0, switch=0, data=0. Bubbles are legal mid-tile (`in_valid` low in STREAM).
- `vec_count`:
  - Cleared to 0 when entering IDLE.
  - Incremented on each accept.
  - Holds through DRAIN.
- No arithmetic on the data; no saturation; width is preserved exactly.

## Timing
- Reset values: `out_input`=0, `out_valid`=0, `out_switch`=0, `in_ready`=1, `busy`=0, `vec_count`=0. State is IDLE; all skew registers are 0.
- Latency: a vector accepted at edge `t` appears on lane `i` after edge `t+1+i`, i.e. lane 0 one cycle later and lane ROWS-1 ROWS cycles later.
- Throughput: one vector per cycle inside a tile. Tile-to-tile overhead is ROWS-1 cycles of `in_ready`=0.
- DRAIN length counts from the cycle after the `in_last` accept. The last lane's final valid leaves while `in_ready` is already 1 again, so no tiles overlap on any lane.
- `in_ready` is a registered function of state only, with no combinational path from `in_valid`.
- Reset asserted mid-tile clears every stage immediately; any partial wavefront is discarded and no trailing valid appears.
- `in_last` and `in_switch` together on an IDLE accept form a 1-vector tile that carries a switch.

## Structure
- Shared package `tpu_pkg`: `DATA_WIDTH` default, Q8.8 fraction-bit constant, and the state enum `skew_state_e` {IDLE, STREAM, DRAIN}.
- One sub-module: `skew_lane #(DEPTH, DATA_WIDTH)`, a shift register of {data, valid, switch}. Instantiate it once per row with DEPTH=`i+1` using a generate loop.

## Test plan
- ROWS=2, reset, then a 3-vector tile: lane0 = 0x0100, 0x0200, 0x0300 and lane1 = 0x0400, 0x0500, 0x0600, with `in_switch`=1 on the first vector.
  - Lane 0 outputs at cycles t+1..t+3; lane 1 at t+2..t+4.
  - `out_switch` = 1 only with 0x0100 (lane 0) and 0x0400 (lane 1).
  - `vec_count`=3.
- `in_last` on vector 3: `in_ready`=0 for exactly 1 cycle. A back-to-back second tile's lane0 first valid follows the first tile's lane1 last valid with no overlap.
- A bubble mid-tile (`in_valid` low 1 cycle) produces one valid=0, data=0 slot on each lane, staggered by one cycle.
- `in_switch`=1 on the second vector of a tile: no `out_switch` on any lane.
- Assert `rst` one cycle after the first accept: all outputs are 0 at once, `busy`=0, and no valid appears afterwards.
- ROWS=1 single-vector tile with `in_last`: `in_ready` never drops; output at t+1; state returns to IDLE.
